// File: rtl/ofmap_if.sv
// Ofmap writer bus: job configuration, kernel result stream and BRAM write port.
interface ofmap_if #(
   parameter int ACC_BW  = 21,
   parameter int OF_BW   = 8,
   parameter int BRAM_BW = 32,
   parameter int CNT_BW  = 16
);
   localparam int LANES = BRAM_BW / OF_BW;

   logic                      i_start;
   logic [31:0]               i_bram_base_addr;
   logic [CNT_BW-1:0]         i_num_out;
   logic signed [ACC_BW-1:0]  i_bias;
   logic [4:0]                i_shift;
   logic                      i_relu_en;
   logic                      i_valid;
   logic signed [ACC_BW-1:0]  i_result;
   logic [31:0]               o_bram_addr;
   logic                      o_bram_we;
   logic [BRAM_BW-1:0]        o_bram_wdata;
   logic [LANES-1:0]          o_bram_be;
   logic                      o_busy;
   logic                      o_done;

   modport master (
      output i_start, i_bram_base_addr, i_num_out, i_bias, i_shift, i_relu_en,
      output i_valid, i_result,
      input  o_bram_addr, o_bram_we, o_bram_wdata, o_bram_be, o_busy, o_done
   );

   modport slave (
      input  i_start, i_bram_base_addr, i_num_out, i_bias, i_shift, i_relu_en,
      input  i_valid, i_result,
      output o_bram_addr, o_bram_we, o_bram_wdata, o_bram_be, o_busy, o_done
   );
endinterface

// File: rtl/ofmap_writer.sv
// Ofmap writer: bias, rounding shift, optional ReLU and saturation of kernel
// results, packed LANES per word and written to output BRAM.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start; config latched on start
// RUN   | accepting i_valid until i_num_out results are taken
// FLUSH | draining pipeline until the final (possibly partial) word lands
// DONE  | o_done pulse for one cycle, then back to IDLE
module ofmap_writer #(
   parameter int ACC_BW  = 21,
   parameter int OF_BW   = 8,
   parameter int BRAM_BW = 32,
   parameter int CNT_BW  = 16
) (
   input logic    clk,
   input logic    rst_n,
   ofmap_if.slave bus
);
   localparam int LANES  = BRAM_BW / OF_BW;
   localparam int IDX_BW = (LANES > 1) ? $clog2(LANES) : 1;
   // wide enough for the biased sum plus a rounding constant up to 2^30
   localparam int SW     = ACC_BW + 33;
   localparam logic signed [SW-1:0] PMAX = SW'((1 << (OF_BW - 1)) - 1);
   localparam logic signed [SW-1:0] NMIN = ~PMAX;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                   state;
   logic [31:0]              cfg_base;
   logic [CNT_BW-1:0]        cfg_num;
   logic signed [ACC_BW-1:0] cfg_bias;
   logic [4:0]               cfg_shift;
   logic                     cfg_relu;
   logic [CNT_BW-1:0]        acc_cnt;

   logic                     s1_valid, s1_last;
   logic signed [ACC_BW:0]   s1_sum;
   logic                     s2_valid, s2_last;
   logic [OF_BW-1:0]         s2_pix;

   logic [IDX_BW-1:0]        pack_idx;
   logic [BRAM_BW-1:0]       pack_word;
   logic [LANES-1:0]         pack_be;
   logic [31:0]              word_idx;

   logic                     start_ok, accept, last_accept;
   logic signed [SW-1:0]     sum_ext, rnd, shifted, rectified;
   logic [OF_BW-1:0]         pix_next;
   logic [BRAM_BW-1:0]       word_next;
   logic [LANES-1:0]         be_next;
   logic                     flush_word;

   assign start_ok    = (state == IDLE) && bus.i_start;
   assign accept      = (state == RUN) && bus.i_valid;
   assign last_accept = accept && ((acc_cnt + CNT_BW'(1)) == cfg_num);

   // Round-half-up shift, ReLU and saturation of the stage-1 sum
   always_comb begin
      sum_ext = SW'(s1_sum);
      rnd     = '0;
      if (cfg_shift != 5'd0) rnd = SW'(1) << (cfg_shift - 5'd1);
      shifted   = (sum_ext + rnd) >>> cfg_shift;
      rectified = (cfg_relu && (shifted < 0)) ? '0 : shifted;
      if (rectified > PMAX)      pix_next = PMAX[OF_BW-1:0];
      else if (rectified < NMIN) pix_next = NMIN[OF_BW-1:0];
      else                       pix_next = rectified[OF_BW-1:0];
   end

   // Merge the stage-2 pixel into the lane selected by pack_idx
   always_comb begin
      word_next = pack_word;
      be_next   = pack_be;
      for (int k = 0; k < LANES; k++) begin
         if (pack_idx == IDX_BW'(k)) begin
            word_next[k*OF_BW +: OF_BW] = s2_pix;
            be_next[k]                  = 1'b1;
         end
      end
      flush_word = s2_valid && ((pack_idx == IDX_BW'(LANES - 1)) || s2_last);
   end

   // Job sequencing FSM with registered busy/done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cfg_base   <= '0;
         cfg_num    <= '0;
         cfg_bias   <= '0;
         cfg_shift  <= '0;
         cfg_relu   <= 1'b0;
         acc_cnt    <= '0;
         bus.o_busy <= 1'b0;
         bus.o_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  cfg_base   <= bus.i_bram_base_addr;
                  cfg_num    <= bus.i_num_out;
                  cfg_bias   <= bus.i_bias;
                  cfg_shift  <= bus.i_shift;
                  cfg_relu   <= bus.i_relu_en;
                  acc_cnt    <= '0;
                  bus.o_busy <= 1'b1;
                  if (bus.i_num_out == '0) begin
                     state      <= DONE;
                     bus.o_done <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  acc_cnt <= acc_cnt + CNT_BW'(1);
                  if (last_accept) state <= FLUSH;
               end
            end
            FLUSH: begin
               // the only write that can appear with an empty pipeline here is the final one
               if (bus.o_bram_we && !s1_valid && !s2_valid) begin
                  state      <= DONE;
                  bus.o_done <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               bus.o_done <= 1'b0;
               bus.o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-stage arithmetic pipeline: bias add, then shift/ReLU/saturate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sum   <= '0;
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         s2_pix   <= '0;
      end else begin
         s1_valid <= accept;
         s1_last  <= last_accept;
         if (accept) s1_sum <= {bus.i_result[ACC_BW-1], bus.i_result}
                             + {cfg_bias[ACC_BW-1], cfg_bias};
         s2_valid <= s1_valid;
         s2_last  <= s1_valid && s1_last;
         if (s1_valid) s2_pix <= pix_next;
      end
   end

   // Lane packing and BRAM write issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_idx         <= '0;
         pack_word        <= '0;
         pack_be          <= '0;
         word_idx         <= '0;
         bus.o_bram_addr  <= '0;
         bus.o_bram_we    <= 1'b0;
         bus.o_bram_wdata <= '0;
         bus.o_bram_be    <= '0;
      end else begin
         if (flush_word) begin
            bus.o_bram_we    <= 1'b1;
            bus.o_bram_wdata <= word_next;
            bus.o_bram_be    <= be_next;
            bus.o_bram_addr  <= cfg_base + word_idx;
            word_idx         <= word_idx + 32'd1;
            pack_idx         <= '0;
            pack_word        <= '0;
            pack_be          <= '0;
         end else begin
            bus.o_bram_we    <= 1'b0;
            bus.o_bram_wdata <= '0;
            bus.o_bram_be    <= '0;
            if (s2_valid) begin
               pack_word <= word_next;
               pack_be   <= be_next;
               pack_idx  <= pack_idx + IDX_BW'(1);
            end else if (start_ok) begin
               word_idx  <= '0;
               pack_idx  <= '0;
               pack_word <= '0;
               pack_be   <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ofmap_writer.sv
// Self-checking bench for ofmap_writer: expected BRAM writes are queued when a
// job is launched and checked by a monitor as the DUT issues them.
module tb_ofmap_writer;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } wr_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vectors;
   int   miscompares;
   int   wr_count;
   int   done_count;
   int   done_cyc;
   int   last_we_cyc;
   int   wr_cyc[$];
   wr_t  sb[$];

   ofmap_if #(.ACC_BW(21), .OF_BW(8), .BRAM_BW(32), .CNT_BW(16)) bus ();

   ofmap_writer #(.ACC_BW(21), .OF_BW(8), .BRAM_BW(32), .CNT_BW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pop and compare every write, record write/done cycles
   always @(negedge clk) begin
      wr_t exp;
      if (bus.o_done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (bus.o_bram_we) begin
         wr_count++;
         last_we_cyc = cyc;
         wr_cyc.push_back(cyc);
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write addr=%h wdata=%h be=%h (no write expected)",
                     bus.o_bram_addr, bus.o_bram_wdata, bus.o_bram_be);
         end else begin
            exp = sb.pop_front();
            if ({bus.o_bram_addr, bus.o_bram_wdata, bus.o_bram_be} !== {exp.addr, exp.wdata, exp.be}) begin
               miscompares++;
               $display("FAIL write got addr=%h wdata=%h be=%h exp addr=%h wdata=%h be=%h",
                        bus.o_bram_addr, bus.o_bram_wdata, bus.o_bram_be, exp.addr, exp.wdata, exp.be);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference for one output pixel using floor division rather than shifts
   function automatic logic [7:0] model_pix(int res, int bias, int shift, bit relu);
      longint s, d, n, r;
      logic [63:0] rb;
      s = longint'(res) + longint'(bias);
      if (shift == 0) r = s;
      else begin
         d = longint'(1) << shift;
         n = s + d / 2;
         r = n / d;
         if ((n % d) != 0 && n < 0) r = r - 1;
      end
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      rb = r;
      return rb[7:0];
   endfunction

   task automatic push_model(input logic [31:0] base, input int bias, input int shift,
                             input bit relu, input int res[$]);
      logic [31:0] w;
      logic [3:0]  be;
      int          wi;
      w = '0; be = '0; wi = 0;
      for (int i = 0; i < res.size(); i++) begin
         w[(i % 4)*8 +: 8] = model_pix(res[i], bias, shift, relu);
         be[i % 4] = 1'b1;
         if ((i % 4) == 3 || i == res.size() - 1) begin
            sb.push_back('{base + 32'(wi), w, be});
            wi++;
            w = '0; be = '0;
         end
      end
   endtask

   task automatic run_job(input logic [31:0] base, input int bias, input int shift, input bit relu,
                          input int res[$], input int gap_max, input int extra, input bit use_model,
                          output int t_first);
      int d0, w0, num, gap;
      num = res.size();
      if (use_model) push_model(base, bias, shift, relu, res);
      d0 = done_count;
      w0 = wr_count;
      t_first = -1;
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      bus.i_bram_base_addr = base;
      bus.i_num_out = 16'(num);
      bus.i_bias = 21'(bias);
      bus.i_shift = 5'(shift);
      bus.i_relu_en = relu;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      for (int i = 0; i < num; i++) begin
         bus.i_valid = 1'b1;
         bus.i_result = 21'(res[i]);
         if (i == 0) t_first = cyc;
         @(posedge clk); #1;
         bus.i_valid = 1'b0;
         gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (gap) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < extra; i++) begin
         bus.i_valid = 1'b1;
         bus.i_result = 21'h55;
         @(posedge clk); #1;
         bus.i_valid = 1'b0;
      end
      for (int k = 0; k < 300 && done_count == d0; k++) @(negedge clk);
      vectors++;
      if (done_count == d0) begin
         miscompares++;
         $display("FAIL done_timeout got no o_done exp o_done within 300 cycles");
      end else if (num > 0) begin
         vectors++;
         if (done_cyc !== last_we_cyc + 1) begin
            miscompares++;
            $display("FAIL done_latency got done at %0d exp %0d", done_cyc, last_we_cyc + 1);
         end
      end
      vectors++;
      if ((wr_count - w0) !== (num + 3) / 4) begin
         miscompares++;
         $display("FAIL write_count got %0d exp %0d", wr_count - w0, (num + 3) / 4);
      end
      vectors++;
      if (sb.size() !== 0) begin
         miscompares++;
         $display("FAIL missing_writes got %0d pending exp 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      vectors++;
      if ({bus.o_busy, bus.o_done} !== 2'b00) begin
         miscompares++;
         $display("FAIL idle_after_done got busy/done=%b exp 00", {bus.o_busy, bus.o_done});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({bus.o_bram_we, bus.o_bram_be, bus.o_bram_wdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_write got we=%b be=%h wdata=%h exp 0", bus.o_bram_we, bus.o_bram_be, bus.o_bram_wdata);
      end
      vectors++;
      if (bus.o_bram_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_addr got %h exp 0", bus.o_bram_addr);
      end
      vectors++;
      if ({bus.o_busy, bus.o_done} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_status got busy/done=%b exp 00", {bus.o_busy, bus.o_done});
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_job1();
      int q[$];
      int t;
      q = '{256, 24, -24, 16};
      // 16, round(1.5)=2, round(-1.5)=-1, 1
      sb.push_back('{32'h40, 32'h01FF0210, 4'hF});
      run_job(32'h40, 0, 4, 1'b0, q, 0, 0, 1'b0, t);
   endtask

   task automatic test_saturation();
      int q[$];
      int t;
      q = '{100000, -100000};
      sb.push_back('{32'h50, 32'h0000807F, 4'h3});
      run_job(32'h50, 0, 0, 1'b0, q, 1, 0, 1'b0, t);
      q = '{-100000, 5};
      sb.push_back('{32'h60, 32'h00000500, 4'h3});
      run_job(32'h60, 0, 0, 1'b1, q, 0, 0, 1'b0, t);
      q = '{200};
      sb.push_back('{32'h70, 32'h00000000, 4'h1});
      run_job(32'h70, -300, 0, 1'b1, q, 0, 0, 1'b0, t);
   endtask

   task automatic test_partial_word();
      int q[$];
      int t;
      q = '{1, 2, 3, 4, 5, 6};
      sb.push_back('{32'h100, 32'h04030201, 4'hF});
      sb.push_back('{32'h101, 32'h00000605, 4'h3});
      run_job(32'h100, 0, 0, 1'b0, q, 0, 0, 1'b0, t);
   endtask

   task automatic test_zero_and_extra();
      int q[$];
      int t, busy_n, done_n, w0;
      w0 = wr_count;
      busy_n = 0; done_n = 0;
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      bus.i_num_out = 16'd0;
      bus.i_bram_base_addr = 32'h900;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.o_busy) busy_n++;
         if (bus.o_done) done_n++;
      end
      vectors++;
      if (busy_n !== 1 || done_n !== 1) begin
         miscompares++;
         $display("FAIL zero_job got busy=%0d done=%0d cycles exp 1 and 1", busy_n, done_n);
      end
      vectors++;
      if (wr_count !== w0) begin
         miscompares++;
         $display("FAIL zero_job_writes got %0d exp 0", wr_count - w0);
      end
      q = '{3, 4};
      sb.push_back('{32'h180, 32'h00000403, 4'h3});
      run_job(32'h180, 0, 0, 1'b0, q, 0, 3, 1'b0, t);
   endtask

   task automatic test_back_to_back();
      int q[$];
      int t;
      q = '{10, -20, 30, -40, 50, -60, 70, -80};
      wr_cyc.delete();
      run_job(32'h80, 7, 1, 1'b0, q, 0, 0, 1'b1, t);
      vectors++;
      if (wr_cyc.size() !== 2) begin
         miscompares++;
         $display("FAIL b2b_count got %0d writes exp 2", wr_cyc.size());
      end else if (wr_cyc[0] !== t + 6 || wr_cyc[1] !== t + 10) begin
         miscompares++;
         $display("FAIL b2b_latency got %0d,%0d exp %0d,%0d", wr_cyc[0] - t, wr_cyc[1] - t, 6, 10);
      end
   endtask

   task automatic test_reset_mid_job();
      int q[$];
      int t, w0;
      @(posedge clk); #1;
      bus.i_start = 1'b1;
      bus.i_num_out = 16'd4;
      bus.i_bram_base_addr = 32'h200;
      bus.i_bias = '0; bus.i_shift = '0; bus.i_relu_en = 1'b0;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.i_valid = 1'b1; bus.i_result = 21'(i + 9);
         @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.o_busy, bus.o_done, bus.o_bram_we, bus.o_bram_be, bus.o_bram_wdata, bus.o_bram_addr} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs got busy=%b addr=%h exp all 0", bus.o_busy, bus.o_bram_addr);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      w0 = wr_count;
      repeat (10) @(posedge clk);
      #1;
      vectors++;
      if (wr_count !== w0 || bus.o_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_quiet got writes=%0d busy=%b exp 0 and 0", wr_count - w0, bus.o_busy);
      end
      q = '{-7, 8, 127, -128};
      run_job(32'h300, 3, 1, 1'b0, q, 1, 0, 1'b1, t);
   endtask

   task automatic test_random();
      int q[$];
      int t, n, bias, shift;
      bit relu;
      for (int j = 0; j < 4; j++) begin
         q.delete();
         n = int'($urandom_range(1, 11));
         for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 2097151)) - 1048576);
         bias  = int'($urandom_range(0, 10000)) - 5000;
         shift = int'($urandom_range(0, 14));
         relu  = 1'($urandom_range(0, 1));
         run_job(32'hFFFF_FFFE - 32'(j), bias, shift, relu, q, 2, 0, 1'b1, t);
      end
   endtask

   initial begin
      cyc = 0; vectors = 0; miscompares = 0;
      wr_count = 0; done_count = 0; done_cyc = 0; last_we_cyc = 0;
      bus.i_start = 1'b0; bus.i_bram_base_addr = '0; bus.i_num_out = '0;
      bus.i_bias = '0; bus.i_shift = '0; bus.i_relu_en = 1'b0;
      bus.i_valid = 1'b0; bus.i_result = '0;
      test_reset();
      test_job1();
      test_saturation();
      test_partial_word();
      test_zero_and_extra();
      test_back_to_back();
      test_reset_mid_job();
      test_random();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
